// File: rtl/page_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : page_scan_pkg
//  Purpose  : Shared types and helpers for the PAGE scan master.
//             - state_t     : scan FSM state encoding
//             - idx_width() : bit width of the rail index (covers 0..VRAILS)
//  Revision : 1.0  initial release
// ============================================================================
package page_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FIND    = 3'd1,
    S_WR_PAGE = 3'd2,
    S_CHECK   = 3'd3,
    S_SETTLE  = 3'd4,
    S_READ    = 3'd5,
    S_EMIT    = 3'd6,
    S_FINISH  = 3'd7
  } state_t;

  // The index must be able to hold VRAILS itself, which marks end of scan.
  function automatic int idx_width(input int rails);
    return $clog2(rails + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/page_find_next.sv
`default_nettype none
// ============================================================================
//  Module   : page_find_next
//  Purpose  : Combinational search for the lowest set mask bit at an index
//             greater than or equal to i_idx.
//  Ports    : i_mask  - rail mask (bit n = rail n monitored)
//             i_idx   - first index to consider
//             o_found - a qualifying bit exists
//             o_k     - index of that bit (0 when none found)
//  Revision : 1.0  initial release
// ============================================================================
module page_find_next #(
  parameter int VRAILS = 4,
  parameter int IW     = 3
) (
  input  logic [VRAILS-1:0] i_mask,
  input  logic [IW-1:0]     i_idx,
  output logic              o_found,
  output logic [IW-1:0]     o_k
);

  // Scanning from the top down lets the lowest qualifying bit win last.
  always_comb begin
    o_found = 1'b0;
    o_k     = '0;
    for (int n = VRAILS - 1; n >= 0; n--) begin
      if (i_mask[n] && (IW'(n) >= i_idx)) begin
        o_found = 1'b1;
        o_k     = IW'(n);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/page_scan_master.sv
`default_nettype none
// ============================================================================
//  Module   : page_scan_master
//  Purpose  : Walks every monitored VOUT rail, writes the rail index into the
//             PAGE register, confirms acceptance, then reads one telemetry
//             word per rail and emits it as a sample.
//  Ports    : CLOCK/RESET_N           - clock, async active-low reset
//             START/VALID_PAGE        - scan request and rail mask
//             REG_SELECT/REG_WRITE/DATA_OUT, PAGE_Q/ALARM_IN
//                                     - PAGE register write side and status
//             RD_REQ/RD_ACK/RD_DATA   - telemetry read handshake
//             SAMPLE_VALID/PAGE/DATA  - per-rail sample output
//             BUSY/DONE/ERROR         - scan status (ERROR is sticky)
//  Revision : 1.0  initial release
// ============================================================================
module page_scan_master
  import page_scan_pkg::*;
#(
  parameter int P_WIDTH        = 5,
  parameter int VRAILS         = 4,
  parameter int D_WIDTH        = 16,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic               START,
  input  logic [VRAILS-1:0]  VALID_PAGE,
  output logic               REG_SELECT,
  output logic               REG_WRITE,
  output logic [P_WIDTH-1:0] DATA_OUT,
  input  logic [P_WIDTH-1:0] PAGE_Q,
  input  logic               ALARM_IN,
  output logic               RD_REQ,
  input  logic               RD_ACK,
  input  logic [D_WIDTH-1:0] RD_DATA,
  output logic               SAMPLE_VALID,
  output logic [P_WIDTH-1:0] SAMPLE_PAGE,
  output logic [D_WIDTH-1:0] SAMPLE_DATA,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERROR
);

  localparam int             IW         = idx_width(VRAILS);
  localparam logic [IW-1:0]  C_LAST_IDX = IW'(VRAILS);
  localparam logic [15:0]    C_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     C_SETTLE   = 8'(SETTLE_CYCLES);

  state_t               r_state;
  logic [IW-1:0]        r_idx;
  logic [VRAILS-1:0]    r_mask;
  logic [7:0]           r_settle_cnt;
  logic [15:0]          r_tmo_cnt;
  logic                 r_reg_wr;
  logic [P_WIDTH-1:0]   r_data_out;
  logic                 r_rd_req;
  logic                 r_sample_valid;
  logic [P_WIDTH-1:0]   r_sample_page;
  logic [D_WIDTH-1:0]   r_sample_data;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;

  state_t               w_next;
  logic [IW-1:0]        w_idx_nxt;
  logic [IW-1:0]        w_idx_inc;
  logic [P_WIDTH-1:0]   w_idx_ext;
  logic                 w_found;
  logic [IW-1:0]        w_k;
  logic                 w_start_ok;
  logic                 w_set_err;
  logic                 w_capture;

  page_find_next #(
    .VRAILS (VRAILS),
    .IW     (IW)
  ) u_find (
    .i_mask  (r_mask),
    .i_idx   (r_idx),
    .o_found (w_found),
    .o_k     (w_k)
  );

  // Index advance saturates at VRAILS so it can never wrap back into range.
  assign w_idx_inc = (r_idx == C_LAST_IDX) ? r_idx : r_idx + 1'b1;
  assign w_idx_ext = P_WIDTH'(r_idx);

  always_comb begin
    w_next     = r_state;
    w_idx_nxt  = r_idx;
    w_start_ok = 1'b0;
    w_set_err  = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_start_ok = 1'b1;
          w_idx_nxt  = '0;
          w_next     = S_FIND;
        end
      end
      S_FIND: begin
        if (w_found) begin
          w_idx_nxt = w_k;
          w_next    = S_WR_PAGE;
        end else begin
          w_next    = S_FINISH;
        end
      end
      S_WR_PAGE: w_next = S_CHECK;
      S_CHECK: begin
        // PAGE_Q reflects the write issued in the previous cycle.
        if (ALARM_IN || (PAGE_Q != w_idx_ext)) begin
          w_set_err = 1'b1;
          w_idx_nxt = w_idx_inc;
          w_next    = S_FIND;
        end else if (SETTLE_CYCLES == 0) begin
          w_next    = S_READ;
        end else begin
          w_next    = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_settle_cnt <= 8'd1) begin
          w_next = S_READ;
        end
      end
      S_READ: begin
        // An ack on the final timeout cycle still wins.
        if (RD_ACK) begin
          w_capture = 1'b1;
          w_next    = S_EMIT;
        end else if (r_tmo_cnt == C_TMO_LAST) begin
          w_set_err = 1'b1;
          w_idx_nxt = w_idx_inc;
          w_next    = S_FIND;
        end
      end
      S_EMIT: begin
        w_idx_nxt = w_idx_inc;
        w_next    = S_FIND;
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // cycle in which the FSM occupies that state.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_mask         <= '0;
      r_settle_cnt   <= '0;
      r_tmo_cnt      <= '0;
      r_reg_wr       <= 1'b0;
      r_data_out     <= '0;
      r_rd_req       <= 1'b0;
      r_sample_valid <= 1'b0;
      r_sample_page  <= '0;
      r_sample_data  <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_idx          <= w_idx_nxt;
      r_reg_wr       <= (w_next == S_WR_PAGE);
      r_data_out     <= (w_next == S_WR_PAGE) ? P_WIDTH'(w_idx_nxt) : '0;
      r_rd_req       <= (w_next == S_READ);
      r_sample_valid <= (w_next == S_EMIT);
      r_busy         <= (w_next != S_IDLE) && (w_next != S_FINISH);
      r_done         <= (w_next == S_FINISH);

      if (w_start_ok) begin
        r_mask <= VALID_PAGE;
      end

      if (w_start_ok) begin
        r_error <= 1'b0;
      end else if (w_set_err) begin
        r_error <= 1'b1;
      end

      if (r_state == S_CHECK) begin
        r_settle_cnt <= C_SETTLE;
      end else if (r_state == S_SETTLE) begin
        r_settle_cnt <= r_settle_cnt - 8'd1;
      end

      if (r_state == S_READ) begin
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end else begin
        r_tmo_cnt <= '0;
      end

      if (w_capture) begin
        r_sample_page <= w_idx_ext;
        r_sample_data <= RD_DATA;
      end
    end
  end

  assign REG_SELECT   = r_reg_wr;
  assign REG_WRITE    = r_reg_wr;
  assign DATA_OUT     = r_data_out;
  assign RD_REQ       = r_rd_req;
  assign SAMPLE_VALID = r_sample_valid;
  assign SAMPLE_PAGE  = r_sample_page;
  assign SAMPLE_DATA  = r_sample_data;
  assign BUSY         = r_busy;
  assign DONE         = r_done;
  assign ERROR        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_page_scan_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_page_scan_master
//  Purpose  : Self-checking bench for page_scan_master. A bench-side PAGE
//             register and telemetry responder react to the DUT; a monitor
//             logs writes, samples and request lengths; each scan is compared
//             against an outcome computed from the rail mask and the
//             per-rail responder configuration.
//  Revision : 1.0  initial release
// ============================================================================
module tb_page_scan_master;

  localparam int P_WIDTH = 5;
  localparam int VRAILS  = 4;
  localparam int D_WIDTH = 16;
  localparam int SETTLE  = 2;
  localparam int TMO     = 255;

  logic               CLOCK = 1'b0;
  logic               RESET_N = 1'b0;
  logic               START = 1'b0;
  logic [VRAILS-1:0]  VALID_PAGE = '0;
  logic               REG_SELECT, REG_WRITE;
  logic [P_WIDTH-1:0] DATA_OUT;
  logic [P_WIDTH-1:0] PAGE_Q = '0;
  logic               ALARM_IN = 1'b0;
  logic               RD_REQ;
  logic               RD_ACK = 1'b0;
  logic [D_WIDTH-1:0] RD_DATA = '0;
  logic               SAMPLE_VALID;
  logic [P_WIDTH-1:0] SAMPLE_PAGE;
  logic [D_WIDTH-1:0] SAMPLE_DATA;
  logic               BUSY, DONE, ERROR;

  page_scan_master #(
    .P_WIDTH(P_WIDTH), .VRAILS(VRAILS), .D_WIDTH(D_WIDTH),
    .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START), .VALID_PAGE(VALID_PAGE),
    .REG_SELECT(REG_SELECT), .REG_WRITE(REG_WRITE), .DATA_OUT(DATA_OUT),
    .PAGE_Q(PAGE_Q), .ALARM_IN(ALARM_IN), .RD_REQ(RD_REQ), .RD_ACK(RD_ACK),
    .RD_DATA(RD_DATA), .SAMPLE_VALID(SAMPLE_VALID), .SAMPLE_PAGE(SAMPLE_PAGE),
    .SAMPLE_DATA(SAMPLE_DATA), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
  );

  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  // Per-rail responder behaviour
  bit                 alarm_cfg   [VRAILS];
  bit                 corrupt_cfg [VRAILS];
  int                 delay_cfg   [VRAILS];
  logic [D_WIDTH-1:0] data_cfg    [VRAILS];

  // Monitor log
  logic [P_WIDTH-1:0]         wr_q [$];
  logic [P_WIDTH+D_WIDTH-1:0] smp_q [$];
  int                         len_q [$];
  int busy_n, done_n, done_cyc, overlap_n, strobe_bad;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({REG_SELECT, REG_WRITE, DATA_OUT, RD_REQ, SAMPLE_VALID,
                SAMPLE_PAGE, SAMPLE_DATA, BUSY, DONE, ERROR});
  endfunction

  // PAGE register and telemetry responder. Acks come delay_cfg+1 cycles
  // after RD_REQ rises, which may land after the DUT has already given up.
  initial begin
    logic w;
    logic [P_WIDTH-1:0] d;
    logic ack_now;
    int age;
    int cur;
    age = 0;
    cur = 0;
    forever begin
      @(negedge CLOCK);
      w = REG_WRITE;
      d = DATA_OUT;
      if (w) cur = int'(d);
      ack_now = RD_REQ && (cur < VRAILS) && (age == delay_cfg[cur]);
      if (RD_REQ) age++; else age = 0;
      @(posedge CLOCK);
      #1;
      if (w) begin
        PAGE_Q   = corrupt_cfg[cur] ? (d ^ 5'd1) : d;
        ALARM_IN = alarm_cfg[cur];
      end else begin
        ALARM_IN = 1'b0;
      end
      RD_ACK  = ack_now;
      RD_DATA = ack_now ? data_cfg[cur] : 16'($urandom);
    end
  end

  initial begin
    int run;
    run = 0;
    forever begin
      @(negedge CLOCK);
      if (REG_WRITE) begin
        wr_q.push_back(DATA_OUT);
        if (!REG_SELECT) strobe_bad++;
      end
      if (SAMPLE_VALID) smp_q.push_back({SAMPLE_PAGE, SAMPLE_DATA});
      if (RD_REQ) run++;
      else if (run > 0) begin
        len_q.push_back(run);
        run = 0;
      end
      if (BUSY) busy_n++;
      if (DONE) begin
        done_n++;
        done_cyc = cyc;
        if (BUSY) overlap_n++;
      end
    end
  end

  task automatic clear_log();
    wr_q.delete();
    smp_q.delete();
    len_q.delete();
    busy_n = 0; done_n = 0; done_cyc = 0; overlap_n = 0; strobe_bad = 0;
  endtask

  task automatic default_cfg();
    for (int p = 0; p < VRAILS; p++) begin
      alarm_cfg[p]   = 1'b0;
      corrupt_cfg[p] = 1'b0;
      delay_cfg[p]   = 0;
      data_cfg[p]    = 16'h1000 + 16'(p);
    end
  endtask

  task automatic start_scan(input logic [VRAILS-1:0] mask);
    clear_log();
    VALID_PAGE = mask;
    START      = 1'b1;
    start_cyc  = cyc;
    @(posedge CLOCK);
    #1;
    START      = 1'b0;
    VALID_PAGE = 4'($urandom);
  endtask

  // Wait for DONE (bounded); optionally re-pulse START with a new mask mid-scan.
  task automatic wait_done(input bit disturb, input logic [VRAILS-1:0] mask);
    for (int k = 1; k < 8000 && done_n == 0; k++) begin
      @(posedge CLOCK);
      #1;
      if (disturb && k == 2) begin
        START      = 1'b1;
        VALID_PAGE = ~mask;
      end else if (disturb && k == 3) begin
        START = 1'b0;
      end
    end
    check("done_seen", 64'(done_n > 0), 64'd1);
    repeat (3) @(posedge CLOCK);
    #1;
  endtask

  // Expected scan outcome from the rail mask and responder configuration.
  task automatic check_scan(input string tag, input logic [VRAILS-1:0] mask);
    logic [P_WIDTH-1:0]         ew [$];
    logic [P_WIDTH+D_WIDTH-1:0] es [$];
    int el [$];
    int lat;
    bit err;
    int r;
    lat = 2;
    err = 1'b0;
    for (int p = 0; p < VRAILS; p++) begin
      if (mask[p]) begin
        ew.push_back(P_WIDTH'(p));
        lat += 3;
        if (alarm_cfg[p] || corrupt_cfg[p]) begin
          err = 1'b1;
        end else begin
          r = (delay_cfg[p] + 2 <= TMO) ? delay_cfg[p] + 2 : TMO;
          el.push_back(r);
          lat += SETTLE + r;
          if (delay_cfg[p] + 2 <= TMO) begin
            es.push_back({P_WIDTH'(p), data_cfg[p]});
            lat += 1;
          end else begin
            err = 1'b1;
          end
        end
      end
    end
    check({tag, ".n_wr"}, 64'(wr_q.size()), 64'(ew.size()));
    for (int i = 0; i < ew.size() && i < wr_q.size(); i++)
      check({tag, ".wr_page"}, 64'(wr_q[i]), 64'(ew[i]));
    check({tag, ".n_smp"}, 64'(smp_q.size()), 64'(es.size()));
    for (int i = 0; i < es.size() && i < smp_q.size(); i++)
      check({tag, ".sample"}, 64'(smp_q[i]), 64'(es[i]));
    check({tag, ".n_req"}, 64'(len_q.size()), 64'(el.size()));
    for (int i = 0; i < el.size() && i < len_q.size(); i++)
      check({tag, ".req_len"}, 64'(len_q[i]), 64'(el[i]));
    check({tag, ".done_lat"}, 64'(done_cyc - start_cyc), 64'(lat));
    check({tag, ".done_cnt"}, 64'(done_n), 64'd1);
    check({tag, ".busy_cyc"}, 64'(busy_n), 64'(lat - 1));
    check({tag, ".done_busy"}, 64'(overlap_n), 64'd0);
    check({tag, ".strobes"}, 64'(strobe_bad), 64'd0);
    check({tag, ".error"}, 64'(ERROR), 64'(err));
    check({tag, ".idle"}, 64'({BUSY, RD_REQ, REG_WRITE}), 64'd0);
  endtask

  task automatic scan(input string tag, input logic [VRAILS-1:0] mask, input bit disturb);
    start_scan(mask);
    wait_done(disturb && (mask != 0), mask);
    check_scan(tag, mask);
  endtask

  initial begin
    int rv;
    logic [VRAILS-1:0] m;
    default_cfg();
    clear_log();
    RESET_N = 1'b0;
    repeat (3) @(posedge CLOCK);
    @(negedge CLOCK);
    check("reset_outs", all_outs(), 64'd0);
    @(posedge CLOCK);
    #1;
    RESET_N = 1'b1;
    repeat (2) @(posedge CLOCK);
    #1;

    default_cfg();
    scan("mask1011", 4'b1011, 1'b0);

    scan("mask0000", 4'b0000, 1'b0);

    alarm_cfg[0] = 1'b1;
    scan("alarm", 4'b0001, 1'b0);

    default_cfg();
    delay_cfg[0] = 1000;
    scan("timeout", 4'b0011, 1'b0);

    default_cfg();
    delay_cfg[0] = TMO - 2;
    delay_cfg[1] = TMO - 1;
    corrupt_cfg[3] = 1'b1;
    scan("ack_edge", 4'b1011, 1'b0);

    default_cfg();
    scan("disturb", 4'b0101, 1'b1);

    // Reset during SETTLE: outputs clear at once and no DONE appears.
    default_cfg();
    start_scan(4'b0001);
    repeat (3) @(posedge CLOCK);
    #3;
    RESET_N = 1'b0;
    #1;
    check("rst_mid_outs", all_outs(), 64'd0);
    repeat (3) @(posedge CLOCK);
    #1;
    RESET_N = 1'b1;
    repeat (2) @(posedge CLOCK);
    #1;
    check("rst_mid_nodone", 64'(done_n), 64'd0);

    // ERROR is left set first so the clean scan also shows it being cleared.
    alarm_cfg[2] = 1'b1;
    scan("pre_err", 4'b0100, 1'b0);
    default_cfg();
    for (int p = 0; p < VRAILS; p++) data_cfg[p] = 16'($urandom);
    scan("post_rst", 4'b1111, 1'b0);

    for (int t = 0; t < 8; t++) begin
      m = 4'($urandom);
      for (int p = 0; p < VRAILS; p++) begin
        alarm_cfg[p]   = ($urandom_range(0, 7) == 0);
        corrupt_cfg[p] = ($urandom_range(0, 7) == 0);
        data_cfg[p]    = 16'($urandom);
        rv = $urandom_range(0, 9);
        delay_cfg[p] = (rv < 6) ? $urandom_range(0, 4) :
                       (rv == 6) ? TMO - 2 : (rv == 7) ? TMO - 1 :
                       (rv == 8) ? 1000 : 0;
      end
      scan("random", m, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
